// File: rtl/px_frame_sequencer.sv
// px_frame_sequencer: frame controller for a rolling-readout pixel array.
//   Runs global erase, exposure and ramp-ADC conversion, then reads rows one at a
//   time and hands each row result downstream over a valid/ready handshake.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start, continuous         frame request (IDLE only) / loop back to erase at frame end
//   exp_time                  exposure cycles, latched at frame start (0 behaves as 1)
//   erase, expose, convert    phase strobes
//   ramp_cnt                  ramp/DAC code, counts up during convert, 0 otherwise
//   read, row_sel             row read strobe and one-hot row select
//   out_valid, out_ready      row result handshake, out_row is the presented row index
//   busy, frame_done          not idle / one-cycle pulse after the last row handshake
// Build option:
//   PXSEQ_GAP_CYCLE_EN        inserts one all-strobes-low cycle at each phase boundary
module px_frame_sequencer #(
  parameter int ROWS      = 2,
  parameter int ERASE_CYC = 5,
  parameter int READ_CYC  = 5,
  parameter int CNT_W     = 8,
  parameter int EXP_W     = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic                                   continuous,
  input  logic [EXP_W-1:0]                       exp_time,
  output logic                                   erase,
  output logic                                   expose,
  output logic                                   convert,
  output logic [CNT_W-1:0]                       ramp_cnt,
  output logic                                   read,
  output logic [ROWS-1:0]                        row_sel,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_row,
  output logic                                   busy,
  output logic                                   frame_done
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int MW = (EXP_W > CNT_W) ? EXP_W : CNT_W;
  localparam int PW = ($clog2(ERASE_CYC + 1) > $clog2(READ_CYC + 1)) ? $clog2(ERASE_CYC + 1) : $clog2(READ_CYC + 1);
  // One extra bit so the exposure count (up to 2^EXP_W-1) and the full ramp both fit.
  localparam int CW = ((MW > PW) ? MW : PW) + 1;
  localparam logic [CW-1:0] CONV_LAST = {{(CW - CNT_W){1'b0}}, {CNT_W{1'b1}}};
`ifdef PXSEQ_GAP_CYCLE_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, ERASE, EXPOSE, CONVERT, READ, WAIT_ACK, DONE, GAP} state_t;

  state_t          state, state_n, nxt, nxt_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [RW-1:0]   row, row_n;
  logic [EXP_W-1:0] exp_lat;
  logic            lat;
  logic            erase_d, expose_d, convert_d, read_d, valid_d, busy_d, done_d;
  logic [CNT_W-1:0] ramp_d;
  logic [ROWS-1:0] sel_d;
  logic [RW-1:0]   out_row_d;

  // State, datapath and registered outputs. Outputs are decoded from the next
  // state so each strobe lines up exactly with its phase cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      nxt        <= IDLE;
      cnt        <= '0;
      row        <= '0;
      exp_lat    <= EXP_W'(1);
      erase      <= 1'b0;
      expose     <= 1'b0;
      convert    <= 1'b0;
      ramp_cnt   <= '0;
      read       <= 1'b0;
      row_sel    <= '0;
      out_valid  <= 1'b0;
      out_row    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      nxt        <= nxt_n;
      cnt        <= cnt_n;
      row        <= row_n;
      exp_lat    <= lat ? ((exp_time == '0) ? EXP_W'(1) : exp_time) : exp_lat;
      erase      <= erase_d;
      expose     <= expose_d;
      convert    <= convert_d;
      ramp_cnt   <= ramp_d;
      read       <= read_d;
      row_sel    <= sel_d;
      out_valid  <= valid_d;
      out_row    <= out_row_d;
      busy       <= busy_d;
      frame_done <= done_d;
    end
  end

  // Next state. cnt counts cycles spent in the current phase and restarts at 0
  // on every phase change; nxt remembers where a gap cycle leads.
  always_comb begin
    state_n = state;
    nxt_n   = nxt;
    cnt_n   = cnt + CW'(1);
    row_n   = row;
    lat     = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (start) begin
          state_n = ERASE;
          lat     = 1'b1;
        end
      end
      ERASE:
        if (cnt == CW'(ERASE_CYC - 1)) begin
          state_n = GAP_EN ? GAP : EXPOSE;
          nxt_n   = EXPOSE;
          cnt_n   = '0;
        end
      EXPOSE:
        if (cnt == CW'(exp_lat) - CW'(1)) begin
          state_n = GAP_EN ? GAP : CONVERT;
          nxt_n   = CONVERT;
          cnt_n   = '0;
        end
      CONVERT:
        if (cnt == CONV_LAST) begin
          state_n = GAP_EN ? GAP : READ;
          nxt_n   = READ;
          cnt_n   = '0;
          row_n   = '0;
        end
      READ:
        if (cnt == CW'(READ_CYC - 1)) begin
          state_n = WAIT_ACK;
          cnt_n   = '0;
        end
      WAIT_ACK: begin
        cnt_n = '0;
        if (out_ready) begin
          state_n = (row == RW'(ROWS - 1)) ? DONE : READ;
          row_n   = row + RW'(1);
        end
      end
      DONE: begin
        cnt_n   = '0;
        lat     = continuous;
        state_n = continuous ? (GAP_EN ? GAP : ERASE) : IDLE;
        nxt_n   = ERASE;
      end
      GAP: begin
        cnt_n   = '0;
        state_n = nxt;
      end
    endcase
  end

  // Output decode of the state being entered.
  always_comb begin
    erase_d   = state_n == ERASE;
    expose_d  = state_n == EXPOSE;
    convert_d = state_n == CONVERT;
    ramp_d    = (state_n == CONVERT) ? cnt_n[CNT_W-1:0] : '0;
    read_d    = state_n == READ;
    sel_d     = (state_n == READ) ? (ROWS'(1) << row_n) : '0;
    valid_d   = state_n == WAIT_ACK;
    out_row_d = (state_n == WAIT_ACK) ? row_n : '0;
    busy_d    = state_n != IDLE;
    done_d    = state_n == DONE;
  end
endmodule
